// File: rtl/bit_deserializer.sv
// rtl/bit_deserializer.sv - serial-to-parallel word collector with valid/ready output and sticky overflow
// Optional parity register enabled by defining BIT_DESER_PARITY_EN.
module bit_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             din,
  input  logic             sync_clr,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [CW-1:0]    bit_count,
  output logic             overflow,
  input  logic             clr_ovf
`ifdef BIT_DESER_PARITY_EN
  ,
  output logic             parity
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-2:0] sreg_q, sreg_d;
  logic [CW-1:0]    bit_count_q, bit_count_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             overflow_q, overflow_d;

  logic             accept, last_bit, complete, load, drop;
  logic [WIDTH-1:0] full_word;

  assign accept    = ena & ~sync_clr;
  assign last_bit  = (bit_count_q == CW'(WIDTH - 1));
  assign complete  = accept & last_bit;
  assign full_word = MSB_FIRST ? {sreg_q, din} : {din, sreg_q};
  assign load      = complete & ((state_q == EMPTY) | word_ready);
  assign drop      = complete & (state_q == FULL) & ~word_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (complete) state_d = FULL;
      FULL:    if (word_ready && !complete) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    word_valid = (state_q == FULL);
  end

  // sreg restarts from zero after each completed word so stale bits never leak.
  always_comb begin
    sreg_d      = sreg_q;
    bit_count_d = bit_count_q;
    word_d      = word_q;
    overflow_d  = drop | (overflow_q & ~clr_ovf);
    if (sync_clr) begin
      sreg_d      = '0;
      bit_count_d = '0;
    end else if (accept) begin
      if (last_bit) begin
        sreg_d      = '0;
        bit_count_d = '0;
      end else begin
        sreg_d      = MSB_FIRST ? full_word[WIDTH-2:0] : full_word[WIDTH-1:1];
        bit_count_d = bit_count_q + CW'(1);
      end
    end
    if (load) word_d = full_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q      <= '0;
      bit_count_q <= '0;
      word_q      <= '0;
      overflow_q  <= 1'b0;
    end else begin
      sreg_q      <= sreg_d;
      bit_count_q <= bit_count_d;
      word_q      <= word_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef BIT_DESER_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (load) begin
      parity_q <= ^full_word;
    end
  end

  assign parity = parity_q;
`endif

  assign word      = word_q;
  assign bit_count = bit_count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_bit_deserializer.sv
// tb/tb_bit_deserializer.sv - scoreboard bench for bit_deserializer, MSB-first and LSB-first instances
module tb_bit_deserializer;

  logic clk = 1'b0;
  logic rst, ena, din, sync_clr, word_ready, clr_ovf, ready_l;
  logic [7:0] word_m, word_l;
  logic       vld_m, vld_l, ovf_m, ovf_l;
  logic [2:0] bc_m, bc_l;
`ifdef BIT_DESER_PARITY_EN
  logic       par_m, par_l;
`endif

  logic [7:0] q_m[$];
  logic [7:0] q_l[$];
  int checks = 0;
  int errors = 0;
  int xfer_m = 0;

  assign ready_l = 1'b1;

  always #5 clk = ~clk;

  bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .ena(ena), .din(din), .sync_clr(sync_clr),
    .word(word_m), .word_valid(vld_m), .word_ready(word_ready),
    .bit_count(bc_m), .overflow(ovf_m), .clr_ovf(clr_ovf)
`ifdef BIT_DESER_PARITY_EN
    , .parity(par_m)
`endif
  );

  bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .ena(ena), .din(din), .sync_clr(sync_clr),
    .word(word_l), .word_valid(vld_l), .word_ready(ready_l),
    .bit_count(bc_l), .overflow(ovf_l), .clr_ovf(clr_ovf)
`ifdef BIT_DESER_PARITY_EN
    , .parity(par_l)
`endif
  );

  function automatic logic [7:0] bitrev(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && vld_m && word_ready) begin
      xfer_m++;
      if (q_m.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL msb_unexpected_word actual=%0h required=none", word_m);
      end else begin
        chk("msb_word", {24'd0, word_m}, {24'd0, q_m.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && vld_l && ready_l) begin
      if (q_l.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL lsb_unexpected_word actual=%0h required=none", word_l);
      end else begin
        chk("lsb_word", {24'd0, word_l}, {24'd0, q_l.pop_front()});
      end
    end
  end

  task automatic send_bit(input logic b);
    ena = 1'b1;
    din = b;
    @(posedge clk);
    #1;
    ena = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit push_m, input bit ready_last);
    if (push_m) q_m.push_back(b);
    q_l.push_back(bitrev(b));
    for (int i = 7; i >= 0; i--) begin
      if (i == 0 && ready_last) word_ready = 1'b1;
      send_bit(b[i]);
    end
  endtask

  logic [7:0] stream_pat [8];
  int x0;

  initial begin
    stream_pat = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'hA5, 8'h3C, 8'h96, 8'h69};
    rst = 1'b1; ena = 1'b0; din = 1'b0; sync_clr = 1'b0; word_ready = 1'b0; clr_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_word", {24'd0, word_m}, 32'h0);
    chk("rst_valid", {31'd0, vld_m}, 32'h0);
    chk("rst_bit_count", {29'd0, bc_m}, 32'h0);
    chk("rst_overflow", {31'd0, ovf_m}, 32'h0);
`ifdef BIT_DESER_PARITY_EN
    chk("rst_parity", {31'd0, par_m}, 32'h0);
`endif
    rst = 1'b0;

    // bit order: same bits into both instances
    send_byte(8'hB3, 1'b0, 1'b0);
    chk("order_msb", {24'd0, word_m}, 32'hB3);
    chk("order_msb_valid", {31'd0, vld_m}, 32'h1);
    chk("order_lsb", {24'd0, word_l}, 32'hCD);
`ifdef BIT_DESER_PARITY_EN
    chk("order_parity", {31'd0, par_m}, 32'h1);
`endif

    // asynchronous reset mid-word
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    chk("pre_rst_bit_count", {29'd0, bc_m}, 32'h5);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_word", {24'd0, word_m}, 32'h0);
    chk("async_rst_valid", {31'd0, vld_m}, 32'h0);
    chk("async_rst_bit_count", {29'd0, bc_m}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    send_byte(8'hB2, 1'b1, 1'b0);
    chk("post_rst_word", {24'd0, word_m}, 32'hB2);
    chk("post_rst_valid", {31'd0, vld_m}, 32'h1);

    // back-pressure: second word dropped
    send_byte(8'h5A, 1'b0, 1'b0);
    chk("bp_word_held", {24'd0, word_m}, 32'hB2);
    chk("bp_overflow", {31'd0, ovf_m}, 32'h1);
    chk("bp_valid", {31'd0, vld_m}, 32'h1);
    clr_ovf = 1'b1;
    @(posedge clk);
    #1 clr_ovf = 1'b0;
    chk("clr_ovf", {31'd0, ovf_m}, 32'h0);

    // ready on the completing edge: transfer and reload together
    send_byte(8'h5A, 1'b1, 1'b1);
    chk("simul_overflow", {31'd0, ovf_m}, 32'h0);
    chk("simul_word", {24'd0, word_m}, 32'h5A);
    chk("simul_valid", {31'd0, vld_m}, 32'h1);
    @(posedge clk);
    #1 word_ready = 1'b0;
    chk("drain_valid", {31'd0, vld_m}, 32'h0);

    // continuous streaming, 64 cycles
    word_ready = 1'b1;
    x0 = xfer_m;
    for (int k = 0; k < 8; k++) begin
      send_byte(stream_pat[k], 1'b1, 1'b0);
      chk("stream_wrap", {29'd0, bc_m}, 32'h0);
    end
    @(posedge clk);
    #1;
    chk("stream_count", xfer_m - x0, 32'd8);
    chk("stream_overflow", {31'd0, ovf_m}, 32'h0);
    word_ready = 1'b0;

    // sync_clr with a pending word
    send_byte(8'h96, 1'b1, 1'b0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    chk("pre_clr_bit_count", {29'd0, bc_m}, 32'h3);
    sync_clr = 1'b1; ena = 1'b1; din = 1'b1;
    @(posedge clk);
    #1 sync_clr = 1'b0; ena = 1'b0;
    chk("sync_clr_bit_count", {29'd0, bc_m}, 32'h0);
    chk("sync_clr_lsb_bit_count", {29'd0, bc_l}, 32'h0);
    chk("sync_clr_word", {24'd0, word_m}, 32'h96);
    chk("sync_clr_valid", {31'd0, vld_m}, 32'h1);
    word_ready = 1'b1;
    send_byte(8'h3C, 1'b1, 1'b0);
    chk("clean_word", {24'd0, word_m}, 32'h3C);
    @(posedge clk);
    #1 word_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("msb_queue_empty", q_m.size(), 32'd0);
    chk("lsb_queue_empty", q_l.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
